// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding / load-use hazard controller.
// Provides the stall FSM state enum, the zero-register id and select-width helper.
package hazard_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam int REG_ZERO    = 0;
    localparam int SEL_REGFILE = 0;

    // Width of one bypass select field for n forwarding stages.
    // Value 0 means regfile, so there are n+1 codes.
    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Priority bypass select for one EX operand over NUM_FWD later stages.
// Ports: src (operand reg), fwd_dst/fwd_we (stage dests and RegWrite), sel (0 = regfile, k+1 = stage k).
module fwd_src_sel
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5,
    parameter int SEL_W   = 2
) (
    input  logic [REG_AW-1:0]         src,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dst,
    input  logic [NUM_FWD-1:0]        fwd_we,
    output logic [SEL_W-1:0]          sel
);

    // Walk oldest to youngest so the youngest match is the last write.
    always_comb begin
        sel = SEL_W'(SEL_REGFILE);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we[k] &&
                fwd_dst[k*REG_AW +: REG_AW] != REG_AW'(REG_ZERO) &&
                fwd_dst[k*REG_AW +: REG_AW] == src) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select for NUM_SRC EX operands plus load-use stall FSM (LOAD_LAT cycles).
// Ports: Clk, Reset (async high); src_ex_i/fwd_dst_i/fwd_we_i -> fwd_sel_o;
//   src_id_i, id_valid_i, ex_load_i, ex_we_i, ex_dst_i, flush_i -> stall_o, bubble_o.
// Optional HAZARD_STATS_EN adds fwd_cnt_o and stall_cnt_o saturating event counters.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = sel_w(NUM_FWD)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_SRC*REG_AW-1:0] src_ex_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dst_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    input  logic [NUM_SRC*REG_AW-1:0] src_id_i,
    input  logic                      id_valid_i,
    input  logic                      ex_load_i,
    input  logic                      ex_we_i,
    input  logic [REG_AW-1:0]         ex_dst_i,
    input  logic                      flush_i,
    output logic                      stall_o,
`ifdef HAZARD_STATS_EN
    output logic [31:0]               fwd_cnt_o,
    output logic [31:0]               stall_cnt_o,
`endif
    output logic                      bubble_o
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    hz_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             src_hit;
    logic             detect;
    logic             stall_raw;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_sel #(
            .NUM_FWD (NUM_FWD),
            .REG_AW  (REG_AW),
            .SEL_W   (SEL_W)
        ) u_sel (
            .src     (src_ex_i[i*REG_AW +: REG_AW]),
            .fwd_dst (fwd_dst_i),
            .fwd_we  (fwd_we_i),
            .sel     (fwd_sel_o[i*SEL_W +: SEL_W])
        );
    end

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_id_i[i*REG_AW +: REG_AW] == ex_dst_i) begin
                src_hit = 1'b1;
            end
        end
    end

    assign detect = id_valid_i & ex_load_i & ex_we_i &
                    (ex_dst_i != REG_AW'(REG_ZERO)) & src_hit;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // First stall cycle comes straight from detect; STALL covers the rest.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stall_raw = 1'b0;
        if (flush_i) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (detect) begin
                        stall_raw = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_n = STALL;
                            cnt_n   = CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    stall_raw = 1'b1;
                    cnt_n     = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Reset masks a combinational detect that would otherwise leak out.
    assign stall_o  = stall_raw & ~Reset;
    assign bubble_o = stall_raw & ~Reset;

`ifdef HAZARD_STATS_EN
    logic any_fwd;

    assign any_fwd = |fwd_sel_o;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fwd_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (any_fwd && fwd_cnt_o != 32'hFFFF_FFFF) begin
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            end
            if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: default instance (2 src, 2 stages, LOAD_LAT 1)
// and a wide instance (3 src, 4 stages, LOAD_LAT 3) against a remaining-cycles reference model.
module tb_hazard_forward_ctrl;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    // Default-parameter instance
    logic [9:0]  src_ex1, fwd_dst1, src_id1;
    logic [1:0]  fwd_we1;
    logic [3:0]  fwd_sel1;
    logic        id_valid1, ex_load1, ex_we1, flush1, stall1, bubble1;
    logic [4:0]  ex_dst1;

    // Wide instance
    logic [14:0] src_ex3, src_id3;
    logic [19:0] fwd_dst3;
    logic [3:0]  fwd_we3;
    logic [8:0]  fwd_sel3;
    logic        id_valid3, ex_load3, ex_we3, flush3, stall3, bubble3;
    logic [4:0]  ex_dst3;

`ifdef HAZARD_STATS_EN
    logic [31:0] fwd_cnt1, stall_cnt1, fwd_cnt3, stall_cnt3;
`endif

    hazard_forward_ctrl dut1 (
        .Clk(Clk), .Reset(Reset),
        .src_ex_i(src_ex1), .fwd_dst_i(fwd_dst1), .fwd_we_i(fwd_we1),
        .fwd_sel_o(fwd_sel1), .src_id_i(src_id1), .id_valid_i(id_valid1),
        .ex_load_i(ex_load1), .ex_we_i(ex_we1), .ex_dst_i(ex_dst1),
        .flush_i(flush1), .stall_o(stall1),
`ifdef HAZARD_STATS_EN
        .fwd_cnt_o(fwd_cnt1), .stall_cnt_o(stall_cnt1),
`endif
        .bubble_o(bubble1)
    );

    hazard_forward_ctrl #(
        .NUM_SRC(3), .NUM_FWD(4), .REG_AW(5), .LOAD_LAT(3)
    ) dut3 (
        .Clk(Clk), .Reset(Reset),
        .src_ex_i(src_ex3), .fwd_dst_i(fwd_dst3), .fwd_we_i(fwd_we3),
        .fwd_sel_o(fwd_sel3), .src_id_i(src_id3), .id_valid_i(id_valid3),
        .ex_load_i(ex_load3), .ex_we_i(ex_we3), .ex_dst_i(ex_dst3),
        .flush_i(flush3), .stall_o(stall3),
`ifdef HAZARD_STATS_EN
        .fwd_cnt_o(fwd_cnt3), .stall_cnt_o(stall_cnt3),
`endif
        .bubble_o(bubble3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rem1 = 0, rem3 = 0;
    bit e1, e3;

    // Youngest (lowest index) writing stage whose dest matches and is not r0.
    function automatic int fwd_ref(input logic [4:0] src, input logic [19:0] dsts,
                                   input logic [3:0] we, input int nfwd);
        for (int k = 0; k < nfwd; k++)
            if (we[k] && dsts[k*5 +: 5] != 5'd0 && dsts[k*5 +: 5] == src)
                return k + 1;
        return 0;
    endfunction

    function automatic bit hz_detect(input logic [14:0] srcs, input int nsrc,
                                     input logic v, input logic l, input logic w,
                                     input logic [4:0] d);
        if (!(v && l && w) || d == 5'd0) return 1'b0;
        for (int i = 0; i < nsrc; i++)
            if (srcs[i*5 +: 5] == d) return 1'b1;
        return 1'b0;
    endfunction

    // rem = stall cycles still owed after the current one.
    task automatic model_eval(input bit rst, input bit det, input bit fl, input int lat,
                              inout int rem, output bit st);
        if (rst || fl) begin
            st = 1'b0; rem = 0;
        end else if (rem > 0) begin
            st = 1'b1; rem = rem - 1;
        end else if (det) begin
            st = 1'b1; rem = lat - 1;
        end else begin
            st = 1'b0;
        end
    endtask

    // Called once per cycle after inputs are driven; advances the model past the next edge.
    task automatic settle();
        #1;
        model_eval(Reset, hz_detect({5'd0, src_id1}, 2, id_valid1, ex_load1, ex_we1, ex_dst1),
                   flush1, 1, rem1, e1);
        model_eval(Reset, hz_detect(src_id3, 3, id_valid3, ex_load3, ex_we3, ex_dst3),
                   flush3, 3, rem3, e3);
    endtask

    task automatic idle_inputs();
        src_ex1 = '0; fwd_dst1 = '0; fwd_we1 = '0; src_id1 = '0;
        id_valid1 = 0; ex_load1 = 0; ex_we1 = 0; ex_dst1 = '0; flush1 = 0;
        src_ex3 = '0; fwd_dst3 = '0; fwd_we3 = '0; src_id3 = '0;
        id_valid3 = 0; ex_load3 = 0; ex_we3 = 0; ex_dst3 = '0; flush3 = 0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        idle_inputs();
        Reset = 1'b1;
        src_ex1 = {5'd4, 5'd3}; fwd_dst1 = {5'd5, 5'd1}; fwd_we1 = 2'b00;
        id_valid1 = 1; ex_load1 = 1; ex_we1 = 1; ex_dst1 = 5'd8; src_id1 = {5'd8, 5'd2};
        id_valid3 = 1; ex_load3 = 1; ex_we3 = 1; ex_dst3 = 5'd8; src_id3 = {5'd0, 5'd8, 5'd0};
        settle();
        n_checks++;
        if ({stall1, bubble1, stall3, bubble3} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 0000", {stall1, bubble1, stall3, bubble3});
        end
        n_checks++;
        if (fwd_sel1 !== 4'h0) begin
            n_fail++;
            $display("FAIL t1_defaults_sel: got %h want 0", fwd_sel1);
        end
`ifdef HAZARD_STATS_EN
        n_checks++;
        if ({fwd_cnt1, stall_cnt1} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d %0d want 0 0", fwd_cnt1, stall_cnt1);
        end
`endif
        @(negedge Clk);
        idle_inputs();
        Reset = 1'b0;
        settle();
    endtask

    task automatic test_fwd_directed();
        @(negedge Clk);
        idle_inputs();
        src_ex1 = {5'd0, 5'd1}; fwd_dst1 = {5'd1, 5'd1}; fwd_we1 = 2'b11;
        settle();
        n_checks++;
        if (fwd_sel1 !== 4'b00_01) begin
            n_fail++;
            $display("FAIL t2_youngest: got %b want 0001", fwd_sel1);
        end
        @(negedge Clk);
        src_ex1 = {5'd0, 5'd1}; fwd_dst1 = {5'd0, 5'd2}; fwd_we1 = 2'b11;
        settle();
        n_checks++;
        if (fwd_sel1 !== 4'b00_00) begin
            n_fail++;
            $display("FAIL t2_r0_nofwd: got %b want 0000", fwd_sel1);
        end
        @(negedge Clk);
        src_ex3 = {5'd7, 5'd0, 5'd0};
        fwd_dst3 = {5'd9, 5'd7, 5'd3, 5'd2}; fwd_we3 = 4'b0100;
        settle();
        n_checks++;
        if (fwd_sel3 !== 9'b011_000_000) begin
            n_fail++;
            $display("FAIL t3_stage2: got %b want 011000000", fwd_sel3);
        end
        @(negedge Clk);
        src_ex3 = {5'd0, 5'd0, 5'd0};
        fwd_dst3 = {5'd9, 5'd0, 5'd3, 5'd2}; fwd_we3 = 4'b0100;
        settle();
        n_checks++;
        if (fwd_sel3 !== 9'd0) begin
            n_fail++;
            $display("FAIL t3_dst0: got %b want 0", fwd_sel3);
        end
    endtask

    task automatic test_fwd_random();
        logic [1:0] x1;
        logic [2:0] x3;
        for (int it = 0; it < 60; it++) begin
            @(negedge Clk);
            idle_inputs();
            for (int i = 0; i < 2; i++) src_ex1[i*5 +: 5] = 5'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) fwd_dst1[i*5 +: 5] = 5'($urandom_range(0, 3));
            for (int i = 0; i < 3; i++) src_ex3[i*5 +: 5] = 5'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) fwd_dst3[i*5 +: 5] = 5'($urandom_range(0, 3));
            fwd_we1 = 2'($urandom);
            fwd_we3 = 4'($urandom);
            settle();
            for (int i = 0; i < 2; i++) begin
                x1 = 2'(fwd_ref(src_ex1[i*5 +: 5], {10'd0, fwd_dst1}, {2'b00, fwd_we1}, 2));
                n_checks++;
                if (fwd_sel1[i*2 +: 2] !== x1) begin
                    n_fail++;
                    $display("FAIL fwd_rand1 op%0d: got %0d want %0d", i, fwd_sel1[i*2 +: 2], x1);
                end
            end
            for (int i = 0; i < 3; i++) begin
                x3 = 3'(fwd_ref(src_ex3[i*5 +: 5], fwd_dst3, fwd_we3, 4));
                n_checks++;
                if (fwd_sel3[i*3 +: 3] !== x3) begin
                    n_fail++;
                    $display("FAIL fwd_rand3 op%0d: got %0d want %0d", i, fwd_sel3[i*3 +: 3], x3);
                end
            end
        end
    endtask

    task automatic test_load_lat1();
        @(negedge Clk);
        idle_inputs();
        id_valid1 = 1; ex_load1 = 1; ex_we1 = 1; ex_dst1 = 5'd8; src_id1 = {5'd8, 5'd2};
        settle();
        n_checks++;
        if ({stall1, bubble1} !== 2'b11) begin
            n_fail++;
            $display("FAIL t4_stall: got %b want 11", {stall1, bubble1});
        end
        @(negedge Clk);
        ex_load1 = 0;
        settle();
        n_checks++;
        if ({stall1, bubble1} !== 2'b00) begin
            n_fail++;
            $display("FAIL t4_release: got %b want 00", {stall1, bubble1});
        end
    endtask

    task automatic test_load_lat3();
        logic [3:0] want = 4'b0111;
        logic [2:0] wantf = 3'b001;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            idle_inputs();
            if (c < 2) begin
                id_valid3 = 1; ex_load3 = 1; ex_we3 = 1; ex_dst3 = 5'd8;
                src_id3 = {5'd1, 5'd8, 5'd2};
            end
            settle();
            n_checks++;
            if ({stall3, bubble3} !== {2{want[c]}} || stall3 !== e3) begin
                n_fail++;
                $display("FAIL t5_lat3 c%0d: got %b want %b", c, {stall3, bubble3}, {2{want[c]}});
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            idle_inputs();
            if (c == 0) begin
                id_valid3 = 1; ex_load3 = 1; ex_we3 = 1; ex_dst3 = 5'd8;
                src_id3 = {5'd8, 5'd0, 5'd0};
            end
            if (c == 1) flush3 = 1;
            settle();
            n_checks++;
            if ({stall3, bubble3} !== {2{wantf[c]}}) begin
                n_fail++;
                $display("FAIL t5_flush c%0d: got %b want %b", c, {stall3, bubble3}, {2{wantf[c]}});
            end
        end
    endtask

    task automatic test_hazard_random();
        for (int it = 0; it < 300; it++) begin
            @(negedge Clk);
            idle_inputs();
            id_valid1 = 1'($urandom_range(0, 3) != 0);
            ex_load1  = 1'($urandom);
            ex_we1    = 1'($urandom_range(0, 3) != 0);
            ex_dst1   = 5'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) src_id1[i*5 +: 5] = 5'($urandom_range(0, 3));
            flush1    = 1'($urandom_range(0, 9) == 0);
            id_valid3 = 1'($urandom_range(0, 3) != 0);
            ex_load3  = 1'($urandom);
            ex_we3    = 1'($urandom_range(0, 3) != 0);
            ex_dst3   = 5'($urandom_range(0, 3));
            for (int i = 0; i < 3; i++) src_id3[i*5 +: 5] = 5'($urandom_range(0, 3));
            flush3    = 1'($urandom_range(0, 9) == 0);
            settle();
            n_checks++;
            if ({stall1, bubble1} !== {e1, e1}) begin
                n_fail++;
                $display("FAIL haz_rand1 it%0d: got %b want %b", it, {stall1, bubble1}, {e1, e1});
            end
            n_checks++;
            if ({stall3, bubble3} !== {e3, e3}) begin
                n_fail++;
                $display("FAIL haz_rand3 it%0d: got %b want %b", it, {stall3, bubble3}, {e3, e3});
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge Clk);
        idle_inputs();
        flush1 = 1; flush3 = 1;
        settle();
        @(negedge Clk);
        idle_inputs();
        id_valid3 = 1; ex_load3 = 1; ex_we3 = 1; ex_dst3 = 5'd5; src_id3 = {5'd5, 5'd0, 5'd0};
        settle();
        n_checks++;
        if (stall3 !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_enter: got %b want 1", stall3);
        end
        @(negedge Clk);
        Reset = 1'b1;
        settle();
        n_checks++;
        if ({stall3, bubble3} !== 2'b00) begin
            n_fail++;
            $display("FAIL t6_reset: got %b want 00", {stall3, bubble3});
        end
`ifdef HAZARD_STATS_EN
        n_checks++;
        if ({fwd_cnt3, stall_cnt3} !== 64'd0) begin
            n_fail++;
            $display("FAIL t6_stats: got %0d %0d want 0 0", fwd_cnt3, stall_cnt3);
        end
`endif
        @(negedge Clk);
        idle_inputs();
        Reset = 1'b0;
        settle();
        n_checks++;
        if ({stall3, bubble3} !== 2'b00) begin
            n_fail++;
            $display("FAIL t6_idle: got %b want 00", {stall3, bubble3});
        end
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fwd_directed();
        test_fwd_random();
        test_load_lat1();
        test_load_lat3();
        test_hazard_random();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
